// File: rtl/branch_redirect_unit_pkg.sv
// Shared types and constants for the execute-stage branch redirect path.
// Keeps the cmp_op encoding in one place so decode, comparator and redirect logic agree.
package branch_redirect_unit_pkg;

    localparam int              XLEN    = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } bru_state_e;

    typedef enum logic [2:0] {
        CMP_BEQ  = 3'b000,
        CMP_BNE  = 3'b001,
        CMP_BLT  = 3'b010,
        CMP_BGE  = 3'b011,
        CMP_BLTU = 3'b100,
        CMP_BGEU = 3'b101
    } cmp_op_e;

endpackage

// File: rtl/branch_redirect_unit_target_calc.sv
// Combinational redirect-target and link adder; JALR clears bit 0 of its sum.
module branch_target_calc
    import branch_redirect_unit_pkg::*;
(
    input  logic            i_is_jalr,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_rs1,
    output logic [XLEN-1:0] o_target,
    output logic [XLEN-1:0] o_link
);

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] sum;

    // JALR wins over JAL/branch, so only the JALR flag selects the base.
    assign base     = i_is_jalr ? i_rs1 : i_pc;
    assign sum      = base + i_imm;
    assign o_target = i_is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
    assign o_link   = i_pc + PC_STEP;

endmodule

// File: rtl/branch_redirect_unit.sv
// Fetch PC owner: resolves branch/JAL/JALR redirects, kills IF/ID, then bubbles fetch.
// Build option: define MISALIGN_TRAP_EN to send targets with bit 1 set to TRAP_VEC.
module branch_redirect_unit
    import branch_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic        i_is_branch,
    input  logic        i_is_jal,
    input  logic        i_is_jalr,
    input  logic        i_taken,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_rs1,
    input  logic        i_stall,
    output logic [31:0] o_pc,
    output logic        o_fetch_valid,
    output logic        o_redirect,
    output logic [31:0] o_link,
    output logic        o_misalign
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    bru_state_e      state_q;
    logic [3:0]      cnt_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] next_target;
    logic            redirect_req;
    logic            take_redirect;
    logic            misalign;

    branch_target_calc u_target_calc (
        .i_is_jalr (i_is_jalr),
        .i_pc      (i_pc),
        .i_imm     (i_imm),
        .i_rs1     (i_rs1),
        .o_target  (target),
        .o_link    (o_link)
    );

    assign redirect_req  = i_valid & (i_is_jalr | i_is_jal | (i_is_branch & i_taken));
    assign take_redirect = ~rst & (state_q == ST_RUN) & redirect_req;

`ifdef MISALIGN_TRAP_EN
    assign misalign = take_redirect & target[1];
`else
    assign misalign = 1'b0;
`endif

    assign next_target   = misalign ? TRAP_VEC : target;
    assign o_pc          = pc_q;
    assign o_fetch_valid = ~rst & (state_q == ST_RUN);
    assign o_redirect    = take_redirect;
    assign o_misalign    = misalign;

    // Redirect has priority over stall; the flush counter ignores stall entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (redirect_req) begin
                        pc_q <= next_target;
                        if (FLUSH_CYCLES > 0) begin
                            state_q <= ST_FLUSH;
                            cnt_q   <= FLUSH_INIT;
                        end
                    end else if (!i_stall) begin
                        pc_q <= pc_q + PC_STEP;
                    end
                end
                ST_FLUSH: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Scoreboarded bench for branch_redirect_unit: directed scenarios plus random traffic.
module tb_branch_redirect_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          FLUSH    = 2;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
    localparam int          EXP_W    = 67;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0, i_is_branch = 1'b0, i_is_jal = 1'b0, i_is_jalr = 1'b0;
    logic        i_taken = 1'b0, i_stall = 1'b0;
    logic [31:0] i_pc = '0, i_imm = '0, i_rs1 = '0;
    logic [31:0] o_pc, o_link;
    logic        o_fetch_valid, o_redirect, o_misalign;

    logic [EXP_W-1:0] exp_q[$];
    string            tag_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;

    // Reference state: PC the front end is fetching and bubbles still owed.
    logic [31:0] m_pc;
    int          m_bub;

    branch_redirect_unit #(
        .RESET_PC     (RESET_PC),
        .FLUSH_CYCLES (FLUSH),
        .TRAP_VEC     (TRAP_VEC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .i_is_branch   (i_is_branch),
        .i_is_jal      (i_is_jal),
        .i_is_jalr     (i_is_jalr),
        .i_taken       (i_taken),
        .i_pc          (i_pc),
        .i_imm         (i_imm),
        .i_rs1         (i_rs1),
        .i_stall       (i_stall),
        .o_pc          (o_pc),
        .o_fetch_valid (o_fetch_valid),
        .o_redirect    (o_redirect),
        .o_link        (o_link),
        .o_misalign    (o_misalign)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus: predict this cycle's outputs, apply inputs, advance the model.
    task automatic drive(input logic r, input logic v, input logic br, input logic jal,
                         input logic jalr, input logic tk, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] rs1,
                         input logic st, input string tag);
        logic        req, fv, red, mis;
        logic [31:0] tgt;
        req = v & (jalr | jal | (br & tk));
        tgt = jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
        fv  = !r && (m_bub == 0);
        red = fv && req;
`ifdef MISALIGN_TRAP_EN
        mis = red && tgt[1];
`else
        mis = 1'b0;
`endif
        exp_q.push_back({m_pc, pc + 32'd4, fv, red, mis});
        tag_q.push_back(tag);
        rst = r; i_valid = v; i_is_branch = br; i_is_jal = jal; i_is_jalr = jalr;
        i_taken = tk; i_pc = pc; i_imm = imm; i_rs1 = rs1; i_stall = st;
        @(posedge clk);
        #1;
        if (r) begin
            m_pc  = RESET_PC;
            m_bub = 0;
        end else if (m_bub > 0) begin
            m_bub--;
        end else if (req) begin
            m_pc  = mis ? TRAP_VEC : tgt;
            m_bub = FLUSH;
        end else if (!st) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic idle(input logic st, input string tag);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, st, tag);
    endtask

    task automatic jal_to(input logic [31:0] pc, input logic [31:0] imm, input string tag);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, pc, imm, 32'h0, 1'b0, tag);
    endtask

    // Monitor: every driven cycle produces one output sample, checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EXP_W-1:0] e, g;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            g = {o_pc, o_link, o_fetch_valid, o_redirect, o_misalign};
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL %s: got pc=%h link=%h fv=%b red=%b mis=%b, want pc=%h link=%h fv=%b red=%b mis=%b",
                         t, g[66:35], g[34:3], g[2], g[1], g[0],
                         e[66:35], e[34:3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        m_pc  = RESET_PC;
        m_bub = 0;
        repeat (2) @(posedge clk);
        #1;
        // Reset holds off fetch-valid and any redirect request.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h8, 32'h0, 1'b0, "reset_hold");
        repeat (4) idle(1'b0, "seq_fetch");

        // Taken branch 0x40 - 8, two bubbles, then 0x38 valid.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'hFFFF_FFF8, 32'h0, 1'b0, "br_taken");
        repeat (3) idle(1'b0, "br_flush");

        // JALR with bit-0 clear; a JAL held through the flush must be ignored.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h38, 32'h4, 32'h1001, 1'b0, "jalr");
        repeat (2) jal_to(32'h200, 32'h40, "flush_ignore");
        idle(1'b0, "jalr_land");
        idle(1'b0, "jalr_next");

        // Stall with a not-taken branch holds; a JAL under stall still redirects.
        jal_to(32'h0, 32'h20, "jal_0x20");
        repeat (2) idle(1'b0, "jal_0x20_flush");
        repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h8, 32'h0, 1'b1, "stall_hold");
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h100, 32'h0, 1'b1, "jal_stall");
        repeat (2) idle(1'b1, "jal_stall_flush");
        idle(1'b1, "jal_stall_land");
        idle(1'b0, "jal_stall_next");

        // PC wrap-around and link wrap; invalid JAL does nothing.
        jal_to(32'h0, 32'hFFFF_FFFC, "jal_top");
        repeat (3) idle(1'b0, "wrap");
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h40, 32'h0, 1'b0, "invalid_jal");
        idle(1'b0, "after_invalid");

        // Target with bit 1 set: trap vector when enabled, passes through otherwise.
        jal_to(32'h100, 32'h2, "misalign");
        repeat (3) idle(1'b0, "misalign_land");

        // Reset in the middle of a flush restarts fetch at once.
        jal_to(32'h0, 32'h80, "pre_rst_jal");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, "rst_mid_flush");
        idle(1'b0, "after_rst");

        for (int i = 0; i < 400; i++) begin
            logic r, v, br, jal, jalr, tk, st;
            logic [31:0] pc, imm, rs1;
            r    = ($urandom_range(0, 99) == 0);
            v    = ($urandom_range(0, 3) != 0);
            br   = ($urandom_range(0, 2) == 0);
            jal  = ($urandom_range(0, 5) == 0);
            jalr = ($urandom_range(0, 5) == 0);
            tk   = $urandom_range(0, 1) != 0;
            st   = ($urandom_range(0, 3) == 0);
            pc   = $urandom() & 32'hFFFF_FFFC;
            imm  = 32'($urandom_range(0, 1023)) - 32'd512;
            rs1  = $urandom();
            drive(r, v, br, jal, jalr, tk, pc, imm, rs1, st, "random");
        end

        idle(1'b0, "drain");
        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d samples unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- Execute-stage consumer of the branch comparator's `taken` output. Owns the fetch program counter.
- Resolves conditional branches, JAL and JALR into a redirect target. Drives the PC register and a one-cycle kill pulse for younger stages.
- After every redirect, suppresses fetch-valid for a fixed bubble count while the front end refills.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, cycles o_fetch_valid is held low after a redirect. Legal range 0..15; 0 means no bubble.
- TRAP_VEC, 32'h0000_0100, PC loaded on a misaligned target. Used only when MISALIGN_TRAP_EN is defined.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  EX-stage instruction is valid
- i_is_branch  in  1  EX instruction is a conditional branch
- i_is_jal  in  1  EX instruction is JAL
- i_is_jalr  in  1  EX instruction is JALR
- i_taken  in  1  comparator result for the EX branch
- i_pc  in  32  PC of the EX instruction
- i_imm  in  32  sign-extended immediate
- i_rs1  in  32  rs1 operand (JALR base)
- i_stall  in  1  fetch must hold its PC
- o_pc  out  32  current fetch PC (registered)
- o_fetch_valid  out  1  fetch output is valid this cycle
- o_redirect  out  1  combinational kill pulse for IF/ID this cycle
- o_link  out  32  i_pc + 4, for the rd writeback of JAL/JALR
- o_misalign  out  1  target misaligned trap pulse; constant 0 when the feature is out

Behaviour:
- Reset (clk edge with rst=1):
  - o_pc=RESET_PC; state=RUN; flush counter=0.
  - While rst=1: o_fetch_valid=0 and o_redirect=0.
  - First cycle after rst falls: o_fetch_valid=1.
  - Reset mid-flush aborts the flush immediately.
- Target computation, all mod 2^32 with wrap-around:
  - branch/JAL: i_pc+i_imm.
  - JALR: (i_rs1+i_imm) & ~32'h1.
  - Flag priority: JALR > JAL > branch.
- redirect_req = i_valid & (i_is_jalr | i_is_jal | (i_is_branch & i_taken)). Evaluated only in state RUN.
- o_link = i_pc+4, combinational, always driven (0xFFFF_FFFC gives 0).
- State RUN:
  - redirect_req: o_redirect=1 in the same cycle. Next edge: o_pc<=target. If FLUSH_CYCLES>0, counter<=FLUSH_CYCLES-1 and state<=FLUSH. Redirect overrides i_stall.
  - else if i_stall: o_pc holds.
  - else: o_pc<=o_pc+4 (0xFFFF_FFFC wraps to 0).
  - o_fetch_valid=1.
- State FLUSH:
  - o_fetch_valid=0, o_redirect=0, o_pc holds.
  - redirect_req is ignored; upstream instructions are squashed.
  - Counter decrements each cycle, including under stall. At counter==0, next state is RUN.
  - Total bubble length is exactly FLUSH_CYCLES cycles.
- i_valid=0: no redirect, regardless of flags or i_taken.
- Not-taken branch: behaves as plain sequential fetch.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - In RUN, if redirect_req and target[1]==1, o_redirect=1 and o_misalign=1 for that cycle.
  - o_pc<=TRAP_VEC; FLUSH entered as for a normal redirect.
- Undefined: o_misalign tied 0; target bit 1 passes to o_pc unchanged.

Decomposition:
- Shared package:
  - XLEN=32 and PC_STEP=4.
  - State typedef {RUN, FLUSH}.
  - The 3-bit cmp_op encodings (beq 000, bne 001, blt 010, bge 011, bltu 100, bgeu 101), so decode, comparator and this block agree.
- One sub-module, branch_target_calc: combinational target/link adder with JALR bit-0 clear.

Test Plan:
- Reset, then rst=0 with no stall for 3 cycles → o_pc sequence 0x0,0x4,0x8,0xC; o_fetch_valid=1.
- Taken branch: i_pc=0x40, i_imm=-8, i_taken=1 → o_redirect=1 that cycle. Next o_pc=0x38, then 2 cycles o_fetch_valid=0, then o_pc 0x38 with valid=1.
- JALR: i_rs1=0x1001, i_imm=4 → o_pc=0x1004, o_link=i_pc+4. A second redirect_req held during FLUSH is ignored.
- Stall with not-taken branch: o_pc holds at 0x20. Then a JAL (i_pc=0x10, imm=0x100) with i_stall=1 still redirects → o_pc=0x110.
- Wrap: o_pc=0xFFFF_FFFC, no stall → next o_pc=0x0. i_valid=0 with i_is_jal=1 → no redirect.
- MISALIGN_TRAP_EN: JAL target 0x102 → o_misalign=1, o_pc=0x100 (TRAP_VEC). Without the macro → o_pc=0x102, o_misalign=0.
